// File: rtl/timer0_pkg.sv
// Shared definitions for timer0: register offsets, CTRL bit positions and default widths.
package timer0_pkg;

  localparam int unsigned TIMER0_DATA_WIDTH     = 32;
  localparam int unsigned TIMER0_ADDR_WIDTH     = 4;
  localparam int unsigned TIMER0_INT_BUS_WIDTH  = 1;
  localparam int unsigned TIMER0_PRESCALE_WIDTH = 8;

  localparam int unsigned CTRL_OFFSET     = 32'h0;
  localparam int unsigned COUNT_OFFSET    = 32'h4;
  localparam int unsigned CMP_OFFSET      = 32'h8;
  localparam int unsigned PRESCALE_OFFSET = 32'hC;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_IE_BIT   = 1;
  localparam int unsigned CTRL_PEND_BIT = 2;
  localparam int unsigned CTRL_AR_BIT   = 3;

endpackage

// File: rtl/timer0_prescaler.sv
// Tick divider for timer0: pulses TickOut once every (PrescaleIn+1) enabled cycles.
// Only built when TIMER0_PRESCALER_EN is defined.
`ifdef TIMER0_PRESCALER_EN
module timer0_prescaler
  import timer0_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER0_PRESCALE_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             EnIn,
  input  logic             RestartIn,
  input  logic [WIDTH-1:0] PrescaleIn,
  output logic             TickOut
);

  logic [WIDTH-1:0] cnt;

  // >= so that lowering PRESCALE mid-count never forces a full wrap of cnt
  assign TickOut = EnIn && (cnt >= PrescaleIn);

  always_ff @(posedge Clk) begin
    if (Rst || RestartIn) begin
      cnt <= '0;
    end else if (TickOut) begin
      cnt <= '0;
    end else if (EnIn) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule
`endif

// File: rtl/timer0.sv
// timer0: compare/match timer with one-shot or auto-reload, W1C pending flag and level IRQ.
// Define TIMER0_PRESCALER_EN to add the 8-bit PRESCALE register and tick divider.
module timer0
  import timer0_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = TIMER0_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = TIMER0_ADDR_WIDTH
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic                            WriteEnIn,
  input  logic                            ReadEnIn,
  input  logic [ADDR_WIDTH-1:0]           AddrIn,
  input  logic [DATA_WIDTH-1:0]           WriteDataIn,
  output logic [DATA_WIDTH-1:0]           ReadDataOut,
  output logic [TIMER0_INT_BUS_WIDTH-1:0] Timer0IntOut
);

  localparam logic [ADDR_WIDTH-1:0] OffCtrl     = ADDR_WIDTH'(CTRL_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] OffCount    = ADDR_WIDTH'(COUNT_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] OffCmp      = ADDR_WIDTH'(CMP_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] OffPrescale = ADDR_WIDTH'(PRESCALE_OFFSET);

  logic                  ctrlEn, ctrlIe, ctrlPend, ctrlAr;
  logic [DATA_WIDTH-1:0] count, cmp;
  logic [DATA_WIDTH-1:0] readMux;
  logic                  ctrlWrite, countWrite, cmpWrite;
  logic                  tick, match;

  assign ctrlWrite  = WriteEnIn && (AddrIn == OffCtrl);
  assign countWrite = WriteEnIn && (AddrIn == OffCount);
  assign cmpWrite   = WriteEnIn && (AddrIn == OffCmp);
  assign match      = tick && (count == cmp);

`ifdef TIMER0_PRESCALER_EN
  logic [TIMER0_PRESCALE_WIDTH-1:0] prescale;
  logic                             prescaleWrite, restart;

  assign prescaleWrite = WriteEnIn && (AddrIn == OffPrescale);
  // Only a 0->1 transition of EN realigns the divider; rewriting EN=1 keeps phase
  assign restart = ctrlWrite && WriteDataIn[CTRL_EN_BIT] && !ctrlEn;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      prescale <= '0;
    end else if (prescaleWrite) begin
      prescale <= WriteDataIn[TIMER0_PRESCALE_WIDTH-1:0];
    end
  end

  timer0_prescaler #(
    .WIDTH(TIMER0_PRESCALE_WIDTH)
  ) uPrescaler (
    .Clk       (Clk),
    .Rst       (Rst),
    .EnIn      (ctrlEn),
    .RestartIn (restart),
    .PrescaleIn(prescale),
    .TickOut   (tick)
  );
`else
  assign tick = ctrlEn;
`endif

  always_comb begin
    readMux = '0;
    if (AddrIn == OffCtrl) begin
      readMux = DATA_WIDTH'({ctrlAr, ctrlPend, ctrlIe, ctrlEn});
    end else if (AddrIn == OffCount) begin
      readMux = count;
    end else if (AddrIn == OffCmp) begin
      readMux = cmp;
`ifdef TIMER0_PRESCALER_EN
    end else if (AddrIn == OffPrescale) begin
      readMux = DATA_WIDTH'(prescale);
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ctrlEn       <= 1'b0;
      ctrlIe       <= 1'b0;
      ctrlPend     <= 1'b0;
      ctrlAr       <= 1'b0;
      count        <= '0;
      cmp          <= '1;
      ReadDataOut  <= '0;
      Timer0IntOut <= '0;
    end else begin
      // A software EN write overrides the one-shot self-disable
      if (ctrlWrite) begin
        ctrlEn <= WriteDataIn[CTRL_EN_BIT];
        ctrlIe <= WriteDataIn[CTRL_IE_BIT];
        ctrlAr <= WriteDataIn[CTRL_AR_BIT];
      end else if (match && !ctrlAr) begin
        ctrlEn <= 1'b0;
      end

      // A fresh match beats a simultaneous write-1-to-clear
      if (match) begin
        ctrlPend <= 1'b1;
      end else if (ctrlWrite && WriteDataIn[CTRL_PEND_BIT]) begin
        ctrlPend <= 1'b0;
      end

      if (countWrite) begin
        count <= WriteDataIn;
      end else if (match) begin
        if (ctrlAr) begin
          count <= '0;
        end
      end else if (tick) begin
        count <= count + DATA_WIDTH'(1);
      end

      if (cmpWrite) begin
        cmp <= WriteDataIn;
      end

      if (ReadEnIn) begin
        ReadDataOut <= readMux;
      end

      Timer0IntOut <= ctrlPend & ctrlIe;
    end
  end

endmodule

// File: tb/tb_timer0.sv
// Directed self-checking bench for timer0; expectations are hand-derived cycle by cycle.
module tb_timer0;

  localparam logic [3:0] ACtrl = 4'h0, ACount = 4'h4, ACmp = 4'h8, APre = 4'hC;

`ifdef TIMER0_PRESCALER_EN
  localparam logic [31:0] ExpPre    = 32'd3;
  localparam int          FirstPend = 8;
`else
  localparam logic [31:0] ExpPre    = 32'd0;
  localparam int          FirstPend = 2;
`endif

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        WriteEnIn = 1'b0;
  logic        ReadEnIn = 1'b0;
  logic [3:0]  AddrIn = '0;
  logic [31:0] WriteDataIn = '0;
  logic [31:0] ReadDataOut;
  logic        Timer0IntOut;
  logic [31:0] rdata;
  int          nCompared = 0;
  int          nMismatched = 0;

  timer0 #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .WriteEnIn   (WriteEnIn),
    .ReadEnIn    (ReadEnIn),
    .AddrIn      (AddrIn),
    .WriteDataIn (WriteDataIn),
    .ReadDataOut (ReadDataOut),
    .Timer0IntOut(Timer0IntOut)
  );

  always #5 Clk = ~Clk;

  // All helpers start and end on a falling edge; one rising edge passes inside.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    WriteEnIn = 1'b1; AddrIn = a; WriteDataIn = d;
    @(negedge Clk);
    WriteEnIn = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    ReadEnIn = 1'b1; AddrIn = a;
    @(negedge Clk);
    ReadEnIn = 1'b0;
    d = ReadDataOut;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nCompared++; if (ReadDataOut !== 32'h0) begin nMismatched++; $display("FAIL rst_rdata: got %h want %h", ReadDataOut, 32'h0); end
    nCompared++; if (Timer0IntOut !== 1'b0) begin nMismatched++; $display("FAIL rst_irq: got %b want 0", Timer0IntOut); end
    rd(ACtrl, rdata);
    nCompared++; if (rdata !== 32'h0) begin nMismatched++; $display("FAIL rst_ctrl: got %h want %h", rdata, 32'h0); end
    rd(ACount, rdata);
    nCompared++; if (rdata !== 32'h0) begin nMismatched++; $display("FAIL rst_count: got %h want %h", rdata, 32'h0); end
    rd(APre, rdata);
    nCompared++; if (rdata !== 32'h0) begin nMismatched++; $display("FAIL rst_prescale: got %h want %h", rdata, 32'h0); end
    rd(ACmp, rdata);
    nCompared++; if (rdata !== 32'hFFFF_FFFF) begin nMismatched++; $display("FAIL rst_cmp: got %h want %h", rdata, 32'hFFFF_FFFF); end
    repeat (3) @(negedge Clk);
    nCompared++; if (ReadDataOut !== 32'hFFFF_FFFF) begin nMismatched++; $display("FAIL rdata_hold: got %h want %h", ReadDataOut, 32'hFFFF_FFFF); end
    rd(4'h2, rdata);
    nCompared++; if (rdata !== 32'h0) begin nMismatched++; $display("FAIL unmapped_rd: got %h want %h", rdata, 32'h0); end
    wr(4'h6, 32'h5A5A_5A5A);
    wr(4'h1, 32'h0000_00FF);
    rd(ACmp, rdata);
    nCompared++; if (rdata !== 32'hFFFF_FFFF) begin nMismatched++; $display("FAIL unmapped_wr_cmp: got %h want %h", rdata, 32'hFFFF_FFFF); end
    rd(ACtrl, rdata);
    nCompared++; if (rdata !== 32'h0) begin nMismatched++; $display("FAIL unmapped_wr_ctrl: got %h want %h", rdata, 32'h0); end
    wr(ACtrl, 32'hFFFF_FFF2);
    rd(ACtrl, rdata);
    nCompared++; if (rdata !== 32'h2) begin nMismatched++; $display("FAIL ctrl_upper_bits: got %h want %h", rdata, 32'h2); end
  endtask

  task automatic test_periodic();
    do_reset();
    wr(ACmp, 32'd4);
    wr(ACtrl, 32'hB);                 // edge E0
    for (int k = 1; k <= 11; k++) begin
      ReadEnIn = 1'b1; AddrIn = ACount;
      @(negedge Clk);                 // passes Ek, captures COUNT after E(k-1)
      nCompared++; if (ReadDataOut !== 32'((k - 1) % 5)) begin nMismatched++; $display("FAIL periodic_count[%0d]: got %h want %h", k, ReadDataOut, 32'((k - 1) % 5)); end
      nCompared++; if (Timer0IntOut !== (k >= 6)) begin nMismatched++; $display("FAIL periodic_irq[%0d]: got %b want %b", k, Timer0IntOut, (k >= 6)); end
    end
    ReadEnIn = 1'b0;
    wr(ACtrl, 32'hF);                 // E12: clear PEND, keep running
    rd(ACtrl, rdata);                 // E13
    nCompared++; if (rdata !== 32'hB) begin nMismatched++; $display("FAIL periodic_w1c: got %h want %h", rdata, 32'hB); end
    nCompared++; if (Timer0IntOut !== 1'b0) begin nMismatched++; $display("FAIL periodic_irq_drop: got %b want 0", Timer0IntOut); end
    for (int k = 14; k <= 16; k++) begin
      @(negedge Clk);
      nCompared++; if (Timer0IntOut !== (k == 16)) begin nMismatched++; $display("FAIL periodic_irq2[%0d]: got %b want %b", k, Timer0IntOut, (k == 16)); end
    end
    rd(ACtrl, rdata);
    nCompared++; if (rdata !== 32'hF) begin nMismatched++; $display("FAIL periodic_pend2: got %h want %h", rdata, 32'hF); end
  endtask

  task automatic test_oneshot();
    do_reset();
    wr(ACmp, 32'd2);
    wr(ACtrl, 32'h3);                 // E0, match at E3
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clk);
      nCompared++; if (Timer0IntOut !== (k >= 4)) begin nMismatched++; $display("FAIL oneshot_irq[%0d]: got %b want %b", k, Timer0IntOut, (k >= 4)); end
    end
    rd(ACtrl, rdata);
    nCompared++; if (rdata !== 32'h6) begin nMismatched++; $display("FAIL oneshot_ctrl: got %h want %h", rdata, 32'h6); end
    rd(ACount, rdata);
    nCompared++; if (rdata !== 32'd2) begin nMismatched++; $display("FAIL oneshot_count: got %h want %h", rdata, 32'd2); end
    repeat (10) @(negedge Clk);
    rd(ACount, rdata);
    nCompared++; if (rdata !== 32'd2) begin nMismatched++; $display("FAIL oneshot_hold: got %h want %h", rdata, 32'd2); end
  endtask

  task automatic test_oneshot_en_race();
    do_reset();
    wr(ACmp, 32'd2);
    wr(ACtrl, 32'h3);                 // E0
    repeat (2) @(negedge Clk);
    wr(ACtrl, 32'h3);                 // E3 coincides with the one-shot match
    rd(ACtrl, rdata);
    nCompared++; if (rdata !== 32'h7) begin nMismatched++; $display("FAIL en_race_ctrl: got %h want %h", rdata, 32'h7); end
  endtask

  task automatic test_pend_race();
    do_reset();
    wr(ACmp, 32'd4);
    wr(ACtrl, 32'hB);                 // E0, matches at E5 and E10
    repeat (9) @(negedge Clk);
    wr(ACtrl, 32'hF);                 // W1C lands on E10
    @(negedge Clk);
    nCompared++; if (Timer0IntOut !== 1'b1) begin nMismatched++; $display("FAIL race_irq: got %b want 1", Timer0IntOut); end
    rd(ACtrl, rdata);
    nCompared++; if (rdata !== 32'hF) begin nMismatched++; $display("FAIL race_pend: got %h want %h", rdata, 32'hF); end
    nCompared++; if (Timer0IntOut !== 1'b1) begin nMismatched++; $display("FAIL race_irq2: got %b want 1", Timer0IntOut); end
  endtask

  task automatic test_cmp_zero();
    do_reset();
    wr(ACmp, 32'd0);
    wr(ACtrl, 32'hB);                 // E0, match every tick from E1
    @(negedge Clk);
    nCompared++; if (Timer0IntOut !== 1'b0) begin nMismatched++; $display("FAIL cmp0_irq_e1: got %b want 0", Timer0IntOut); end
    rd(ACount, rdata);
    nCompared++; if (rdata !== 32'd0) begin nMismatched++; $display("FAIL cmp0_count: got %h want %h", rdata, 32'd0); end
    nCompared++; if (Timer0IntOut !== 1'b1) begin nMismatched++; $display("FAIL cmp0_irq_e2: got %b want 1", Timer0IntOut); end
    wr(ACtrl, 32'hF);
    rd(ACtrl, rdata);
    nCompared++; if (rdata !== 32'hF) begin nMismatched++; $display("FAIL cmp0_pend: got %h want %h", rdata, 32'hF); end
  endtask

  task automatic test_prescaler();
    do_reset();
    wr(APre, 32'd3);
    rd(APre, rdata);
    nCompared++; if (rdata !== ExpPre) begin nMismatched++; $display("FAIL prescale_rd: got %h want %h", rdata, ExpPre); end
    wr(ACmp, 32'd1);
    wr(ACtrl, 32'h3);                 // E0
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clk);
      nCompared++; if (Timer0IntOut !== (k >= FirstPend + 1)) begin nMismatched++; $display("FAIL prescale_irq[%0d]: got %b want %b", k, Timer0IntOut, (k >= FirstPend + 1)); end
    end
    rd(ACount, rdata);
    nCompared++; if (rdata !== 32'd1) begin nMismatched++; $display("FAIL prescale_count: got %h want %h", rdata, 32'd1); end
  endtask

  task automatic test_wrap();
    logic [31:0] expCnt [3];
    expCnt = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    do_reset();
    wr(ACmp, 32'd1);
    wr(ACount, 32'hFFFF_FFFE);
    wr(ACtrl, 32'h9);                 // E0, EN|AR
    for (int k = 1; k <= 3; k++) begin
      ReadEnIn = 1'b1; AddrIn = ACount;
      @(negedge Clk);
      nCompared++; if (ReadDataOut !== expCnt[k-1]) begin nMismatched++; $display("FAIL wrap_count[%0d]: got %h want %h", k, ReadDataOut, expCnt[k-1]); end
    end
    ReadEnIn = 1'b0;
    rd(ACtrl, rdata);                 // state after E3: COUNT=1, no PEND yet
    nCompared++; if (rdata !== 32'h9) begin nMismatched++; $display("FAIL wrap_no_pend: got %h want %h", rdata, 32'h9); end
    rd(ACtrl, rdata);                 // state after E4: match at COUNT=1
    nCompared++; if (rdata !== 32'hD) begin nMismatched++; $display("FAIL wrap_pend: got %h want %h", rdata, 32'hD); end
    rd(ACount, rdata);
    nCompared++; if (rdata !== 32'd1) begin nMismatched++; $display("FAIL wrap_reload: got %h want %h", rdata, 32'd1); end
  endtask

  task automatic test_count_priority();
    do_reset();
    wr(ACtrl, 32'h1);                 // E0
    repeat (3) @(negedge Clk);
    wr(ACount, 32'd100);              // E4 overrides increment
    rd(ACount, rdata);
    nCompared++; if (rdata !== 32'd100) begin nMismatched++; $display("FAIL cnt_wr_prio: got %h want %h", rdata, 32'd100); end
    rd(ACount, rdata);
    nCompared++; if (rdata !== 32'd101) begin nMismatched++; $display("FAIL cnt_after_wr: got %h want %h", rdata, 32'd101); end
    wr(ACmp, 32'd50);                 // below COUNT: no match until wrap
    repeat (5) @(negedge Clk);
    rd(ACtrl, rdata);
    nCompared++; if (rdata !== 32'h1) begin nMismatched++; $display("FAIL cmp_below: got %h want %h", rdata, 32'h1); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(ACmp, 32'd1);
    wr(ACtrl, 32'h3);
    repeat (3) @(negedge Clk);        // PEND set, one-shot stopped
    wr(ACmp, 32'hFFFF_FFFF);
    wr(ACount, 32'd6);
    wr(ACtrl, 32'h3);                 // F0
    ReadEnIn = 1'b1; AddrIn = ACount;
    @(negedge Clk);                   // F1: COUNT becomes 7
    ReadEnIn = 1'b0;
    nCompared++; if (ReadDataOut !== 32'd6) begin nMismatched++; $display("FAIL mid_pre_rdata: got %h want %h", ReadDataOut, 32'd6); end
    nCompared++; if (Timer0IntOut !== 1'b1) begin nMismatched++; $display("FAIL mid_pre_irq: got %b want 1", Timer0IntOut); end
    do_reset();
    nCompared++; if (ReadDataOut !== 32'h0) begin nMismatched++; $display("FAIL mid_rdata: got %h want %h", ReadDataOut, 32'h0); end
    nCompared++; if (Timer0IntOut !== 1'b0) begin nMismatched++; $display("FAIL mid_irq: got %b want 0", Timer0IntOut); end
    rd(ACmp, rdata);
    nCompared++; if (rdata !== 32'hFFFF_FFFF) begin nMismatched++; $display("FAIL mid_cmp: got %h want %h", rdata, 32'hFFFF_FFFF); end
    nCompared++; if (Timer0IntOut !== 1'b0) begin nMismatched++; $display("FAIL mid_irq2: got %b want 0", Timer0IntOut); end
    rd(ACtrl, rdata);
    nCompared++; if (rdata !== 32'h0) begin nMismatched++; $display("FAIL mid_ctrl: got %h want %h", rdata, 32'h0); end
    rd(ACount, rdata);
    nCompared++; if (rdata !== 32'h0) begin nMismatched++; $display("FAIL mid_count: got %h want %h", rdata, 32'h0); end
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    test_reset();
    test_periodic();
    test_oneshot();
    test_oneshot_en_race();
    test_pend_race();
    test_cmp_zero();
    test_prescaler();
    test_wrap();
    test_count_priority();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
